// File: rtl/clock_set_pkg.sv
// clock_set_pkg
// Shared types and constants for the time-setting controller:
//   state_t    - controller states (alarm states used only with CLOCK_SET_ALARM_EN)
//   bcd2_t     - one two-digit BCD field (hours or minutes)
//   HR_MAX / MIN_MAX - last legal value of each field before wrapping to 00
//   BLINK_*    - display blink mask codes
//   bcd2_clean - forces each digit of a captured field back into 0..9
package clock_set_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HR,
    SET_MIN,
    SET_AL_HR,
    SET_AL_MIN
  } state_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t HR_MAX  = 8'h23;
  localparam bcd2_t MIN_MAX = 8'h59;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_HR   = 2'b01;
  localparam logic [1:0] BLINK_MIN  = 2'b10;

  // A digit above 9 coming from the counter is replaced by 0 so the value
  // under edit is always legal BCD.
  function automatic bcd2_t bcd2_clean(bcd2_t v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (v[7:4] > 4'd9) ? 4'd0 : v[7:4];
    lo = (v[3:0] > 4'd9) ? 4'd0 : v[3:0];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/clock_set_ctrl_bcd2_inc_wrap.sv
// bcd2_inc_wrap
// Combinational two-digit BCD increment with wrap to 00.
//   val     in  8  current BCD value
//   max_val in  8  last value before wrap (e.g. 8'h23 for hours)
//   inc_val out 8  val + 1 in BCD, or 00 once val has reached max_val
module bcd2_inc_wrap
  import clock_set_pkg::*;
(
  input  bcd2_t val,
  input  bcd2_t max_val,
  output bcd2_t inc_val
);

  // Values at or beyond the maximum wrap to 00; this also keeps an
  // out-of-range hour such as 29 from ever producing a non-BCD digit.
  always_comb begin
    inc_val = 8'h00;
    if (val >= max_val) begin
      inc_val = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      inc_val = {val[7:4] + 4'd1, 4'h0};
    end else begin
      inc_val = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Controller for the HH:MM:SS BCD time counter: produces the once-per-
// PRESCALE-cycles advance enable and runs the mode/inc button sequence used
// to set a new time, which is handed to the counter with a one-cycle load.
// Optional alarm feature: define CLOCK_SET_ALARM_EN.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   mode_btn   in   1   one-cycle pulse: advance setting mode
//   inc_btn    in   1   one-cycle pulse: increment field under edit
//   cur_time   in   24  {hr,min,sec} BCD from the counter
//   tick       out  1   one-cycle counter advance enable
//   load       out  1   one-cycle strobe: counter takes load_time
//   load_time  out  24  {hr,min,00} BCD to load
//   blink      out  2   01 hours, 10 minutes, 00 none
//   alarm_arm  in   1   alarm armed (alarm build only)
//   alarm_out  out  1   alarm active (0 without the alarm build)
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int PRESCALE   = 50_000_000,
  parameter int ALARM_SECS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic [23:0] cur_time,
  output logic        tick,
  output logic        load,
  output logic [23:0] load_time,
  output logic [1:0]  blink,
  input  logic        alarm_arm,
  output logic        alarm_out
);

  localparam int PCW = $clog2(PRESCALE);
  localparam logic [PCW-1:0] PRESC_LAST = PCW'(PRESCALE - 1);

  state_t         state;
  logic [PCW-1:0] presc;
  bcd2_t          sh_hr;
  bcd2_t          sh_min;
  bcd2_t          sh_hr_next;
  bcd2_t          sh_min_next;
  logic           mode_go;

  // Tick is a decode of registered state, so it never fires while setting.
  assign tick = (state == RUN) && (presc == PRESC_LAST);

  // Prescaler parks at 0 outside RUN so a full period elapses after return.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (state != RUN || presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PCW'(1);
    end
  end

  bcd2_inc_wrap u_hr_inc  (.val(sh_hr),  .max_val(HR_MAX),  .inc_val(sh_hr_next));
  bcd2_inc_wrap u_min_inc (.val(sh_min), .max_val(MIN_MAX), .inc_val(sh_min_next));

`ifdef CLOCK_SET_ALARM_EN
  localparam int ACW = $clog2(ALARM_SECS + 1);
  localparam logic [ACW-1:0] AL_LAST = ACW'(ALARM_SECS - 1);

  bcd2_t          al_hr;
  bcd2_t          al_min;
  bcd2_t          al_sh_hr;
  bcd2_t          al_sh_min;
  bcd2_t          al_sh_hr_next;
  bcd2_t          al_sh_min_next;
  logic           al_match;
  logic           al_match_q;
  logic [ACW-1:0] al_cnt;

  bcd2_inc_wrap u_al_hr_inc  (.val(al_sh_hr),  .max_val(HR_MAX),  .inc_val(al_sh_hr_next));
  bcd2_inc_wrap u_al_min_inc (.val(al_sh_min), .max_val(MIN_MAX), .inc_val(al_sh_min_next));

  // A mode pulse that silences a ringing alarm is consumed, not a state change.
  assign mode_go  = mode_btn && !alarm_out;
  assign al_match = (state == RUN) && alarm_arm &&
                    (cur_time == {al_hr, al_min, 8'h00});

  // Alarm fires on the rising edge of a match so that silencing it during
  // the matching second does not immediately re-trigger it.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_out  <= 1'b0;
      al_cnt     <= '0;
      al_match_q <= 1'b0;
    end else begin
      al_match_q <= al_match;
      if (alarm_out) begin
        if (mode_btn || inc_btn) begin
          alarm_out <= 1'b0;
        end else if (tick) begin
          if (al_cnt == AL_LAST) begin
            alarm_out <= 1'b0;
          end
          al_cnt <= al_cnt + ACW'(1);
        end
      end else if (al_match && !al_match_q) begin
        alarm_out <= 1'b1;
        al_cnt    <= '0;
      end
    end
  end
`else
  logic unused_ok;

  assign mode_go   = mode_btn;
  assign alarm_out = 1'b0;
  assign unused_ok = &{1'b0, alarm_arm, cur_time[7:0], (ALARM_SECS > 0)};
`endif

  // Setting sequence. mode has priority over inc in every state; load and
  // load_time are registered so the strobe lands the cycle after the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      sh_hr     <= 8'h00;
      sh_min    <= 8'h00;
      load      <= 1'b0;
      load_time <= 24'h000000;
      blink     <= BLINK_NONE;
`ifdef CLOCK_SET_ALARM_EN
      al_hr     <= 8'h00;
      al_min    <= 8'h00;
      al_sh_hr  <= 8'h00;
      al_sh_min <= 8'h00;
`endif
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (mode_go) begin
            state  <= SET_HR;
            blink  <= BLINK_HR;
            sh_hr  <= bcd2_clean(cur_time[23:16]);
            sh_min <= bcd2_clean(cur_time[15:8]);
          end
        end
        SET_HR: begin
          if (mode_btn) begin
            state <= SET_MIN;
            blink <= BLINK_MIN;
          end else if (inc_btn) begin
            sh_hr <= sh_hr_next;
          end
        end
        SET_MIN: begin
          if (mode_btn) begin
            load      <= 1'b1;
            load_time <= {sh_hr, sh_min, 8'h00};
`ifdef CLOCK_SET_ALARM_EN
            state     <= SET_AL_HR;
            blink     <= BLINK_HR;
            al_sh_hr  <= al_hr;
            al_sh_min <= al_min;
`else
            state     <= RUN;
            blink     <= BLINK_NONE;
`endif
          end else if (inc_btn) begin
            sh_min <= sh_min_next;
          end
        end
`ifdef CLOCK_SET_ALARM_EN
        SET_AL_HR: begin
          if (mode_btn) begin
            state <= SET_AL_MIN;
            blink <= BLINK_MIN;
          end else if (inc_btn) begin
            al_sh_hr <= al_sh_hr_next;
          end
        end
        SET_AL_MIN: begin
          if (mode_btn) begin
            state  <= RUN;
            blink  <= BLINK_NONE;
            al_hr  <= al_sh_hr;
            al_min <= al_sh_min;
          end else if (inc_btn) begin
            al_sh_min <= al_sh_min_next;
          end
        end
`endif
        default: begin
          state <= RUN;
          blink <= BLINK_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
// Bench for clock_set_ctrl with PRESCALE=4. A behavioural model (phase
// number, decimal hours/minutes, cycles-in-RUN counter) predicts every output
// each cycle; directed tables and sequences add fixed expected values.
// Alarm sequences are compiled in when CLOCK_SET_ALARM_EN is defined.
module tb_clock_set_ctrl;

  localparam int PRESCALE   = 4;
  localparam int ALARM_SECS = 30;
`ifdef CLOCK_SET_ALARM_EN
  localparam bit AL_EN = 1'b1;
`else
  localparam bit AL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [23:0] cur_time = 24'h000000;
  logic        tick;
  logic        load;
  logic [23:0] load_time;
  logic [1:0]  blink;
  logic        alarm_arm = 1'b0;
  logic        alarm_out;

  int total = 0;
  int bad = 0;

  clock_set_ctrl #(.PRESCALE(PRESCALE), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_time(cur_time), .tick(tick), .load(load), .load_time(load_time),
    .blink(blink), .alarm_arm(alarm_arm), .alarm_out(alarm_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_phase = 0;      // 0 run, 1 hr, 2 min, 3 alarm hr, 4 alarm min
  int m_run = 0;        // cycles spent in run since entering it
  int m_hr = 0, m_mn = 0, m_ldhr = 0, m_ldmn = 0;
  bit m_load = 0;
  int m_alhr = 0, m_almn = 0, m_ashr = 0, m_asmn = 0;
  bit m_alon = 0, m_prevmatch = 0;
  int m_left = 0;

  function automatic int clean2(logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] bcd(int n);
    logic [3:0] h, l;
    h = 4'(n / 10);
    l = 4'(n % 10);
    return {h, l};
  endfunction

  function automatic int wrapInc(int v, int maxv);
    return (v >= maxv) ? 0 : v + 1;
  endfunction

  task automatic modelStep(input logic m, input logic i, input logic r,
                           input logic [23:0] t, input logic arm);
    bit tick_now, old_alon, match;
    if (r) begin
      m_phase = 0; m_run = 0; m_hr = 0; m_mn = 0; m_ldhr = 0; m_ldmn = 0;
      m_load = 0; m_alhr = 0; m_almn = 0; m_ashr = 0; m_asmn = 0;
      m_alon = 0; m_prevmatch = 0; m_left = 0;
    end else begin
      tick_now = (m_phase == 0) && (m_run % PRESCALE == PRESCALE - 1);
      old_alon = m_alon;
      match = AL_EN && (m_phase == 0) && arm &&
              (t == {bcd(m_alhr), bcd(m_almn), 8'h00});
      m_load = 0;
      case (m_phase)
        0: if (m && !old_alon) begin
             m_phase = 1; m_hr = clean2(t[23:16]); m_mn = clean2(t[15:8]);
           end else m_run++;
        1: if (m) m_phase = 2; else if (i) m_hr = wrapInc(m_hr, 23);
        2: if (m) begin
             m_load = 1; m_ldhr = m_hr; m_ldmn = m_mn;
             if (AL_EN) begin m_phase = 3; m_ashr = m_alhr; m_asmn = m_almn; end
             else begin m_phase = 0; m_run = 0; end
           end else if (i) m_mn = wrapInc(m_mn, 59);
        3: if (m) m_phase = 4; else if (i) m_ashr = wrapInc(m_ashr, 23);
        4: if (m) begin
             m_alhr = m_ashr; m_almn = m_asmn; m_phase = 0; m_run = 0;
           end else if (i) m_asmn = wrapInc(m_asmn, 59);
        default: m_phase = 0;
      endcase
      if (old_alon) begin
        if (m || i) m_alon = 0;
        else if (tick_now) begin
          m_left--;
          if (m_left == 0) m_alon = 0;
        end
      end else if (match && !m_prevmatch) begin
        m_alon = 1; m_left = ALARM_SECS;
      end
      m_prevmatch = match;
    end
  endtask

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic [1:0] eb;
    eb = (m_phase == 1 || m_phase == 3) ? 2'b01 :
         (m_phase == 2 || m_phase == 4) ? 2'b10 : 2'b00;
    checkOutput("model_tick", {31'd0, tick},
                {31'd0, (m_phase == 0) && (m_run % PRESCALE == PRESCALE - 1)});
    checkOutput("model_load", {31'd0, load}, {31'd0, m_load});
    checkOutput("model_load_time", {8'd0, load_time}, {8'd0, bcd(m_ldhr), bcd(m_ldmn), 8'h00});
    checkOutput("model_blink", {30'd0, blink}, {30'd0, eb});
    checkOutput("model_alarm", {31'd0, alarm_out}, {31'd0, m_alon});
  endtask

  // One clock cycle: drive inputs, advance the model, sample after the edge.
  task automatic applyStimulus(input logic m, input logic i, input logic r,
                               input logic [23:0] t, input logic arm);
    mode_btn = m; inc_btn = i; rst = r; cur_time = t; alarm_arm = arm;
    modelStep(m, i, r, t, arm);
    @(posedge clk);
    #1;
    mode_btn = 1'b0; inc_btn = 1'b0; rst = 1'b0;
    checkModel();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 1, 24'h000000, 0);
    applyStimulus(0, 0, 1, 24'h000000, 0);
  endtask

  typedef struct {
    logic        m;
    logic        i;
    logic [23:0] t;
    logic        exp_load;
    logic [23:0] exp_lt;
    logic [1:0]  exp_blink;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] bl_commit, bl_after1;
    logic [23:0] rt;
    bit fell;
    int fall_at;

    // Blink right after commit and one cycle later differ with the alarm
    // build, because commit then moves on to the alarm fields.
    bl_commit = AL_EN ? 2'b01 : 2'b00;
    bl_after1 = AL_EN ? 2'b10 : 2'b00;

    // 23:58 -> hours 00, minutes 00, load 00:00:00; then 08:15 -> 10:16.
    vecs.push_back('{1'b1, 1'b0, 24'h235812, 1'b0, 24'h000000, 2'b01});
    vecs.push_back('{1'b0, 1'b1, 24'h235812, 1'b0, 24'h000000, 2'b01});
    vecs.push_back('{1'b1, 1'b0, 24'h235812, 1'b0, 24'h000000, 2'b10});
    vecs.push_back('{1'b0, 1'b1, 24'h235812, 1'b0, 24'h000000, 2'b10});
    vecs.push_back('{1'b0, 1'b1, 24'h235812, 1'b0, 24'h000000, 2'b10});
    vecs.push_back('{1'b1, 1'b0, 24'h235812, 1'b1, 24'h000000, bl_commit});
    vecs.push_back('{AL_EN, 1'b0, 24'h235812, 1'b0, 24'h000000, bl_after1});
    vecs.push_back('{AL_EN, 1'b0, 24'h235812, 1'b0, 24'h000000, 2'b00});
    vecs.push_back('{1'b1, 1'b0, 24'h081530, 1'b0, 24'h000000, 2'b01});
    vecs.push_back('{1'b0, 1'b1, 24'h081530, 1'b0, 24'h000000, 2'b01});
    vecs.push_back('{1'b0, 1'b1, 24'h081530, 1'b0, 24'h000000, 2'b01});
    vecs.push_back('{1'b1, 1'b0, 24'h081530, 1'b0, 24'h000000, 2'b10});
    vecs.push_back('{1'b0, 1'b1, 24'h081530, 1'b0, 24'h000000, 2'b10});
    vecs.push_back('{1'b1, 1'b0, 24'h081530, 1'b1, 24'h101600, bl_commit});
    vecs.push_back('{AL_EN, 1'b0, 24'h081530, 1'b0, 24'h101600, bl_after1});
    vecs.push_back('{AL_EN, 1'b0, 24'h081530, 1'b0, 24'h101600, 2'b00});

    // Reset state.
    doReset();
    checkOutput("reset_tick", {31'd0, tick}, 32'd0);
    checkOutput("reset_load", {31'd0, load}, 32'd0);
    checkOutput("reset_load_time", {8'd0, load_time}, 32'd0);
    checkOutput("reset_blink", {30'd0, blink}, 32'd0);
    checkOutput("reset_alarm", {31'd0, alarm_out}, 32'd0);

    // Free run: tick is high in the cycles ending at edges 4, 8, 12.
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(0, 0, 0, 24'h120000, 0);
      checkOutput($sformatf("run_tick_%0d", n), {31'd0, tick}, {31'd0, (n % 4) == 3});
      checkOutput("run_no_load", {31'd0, load}, 32'd0);
    end

    // Directed table.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].m, vecs[k].i, 0, vecs[k].t, 0);
      checkOutput($sformatf("vec%0d_load", k), {31'd0, load}, {31'd0, vecs[k].exp_load});
      checkOutput($sformatf("vec%0d_load_time", k), {8'd0, load_time}, {8'd0, vecs[k].exp_lt});
      checkOutput($sformatf("vec%0d_blink", k), {30'd0, blink}, {30'd0, vecs[k].exp_blink});
    end

    // SET_HR from 08: two incs give 10; mode+inc together leaves hours at 10.
    applyStimulus(1, 0, 0, 24'h080000, 0);
    applyStimulus(0, 1, 0, 24'h080000, 0);
    applyStimulus(0, 1, 0, 24'h080000, 0);
    applyStimulus(1, 1, 0, 24'h080000, 0);
    checkOutput("mode_inc_blink", {30'd0, blink}, 32'd2);
    applyStimulus(1, 0, 0, 24'h080000, 0);
    checkOutput("mode_inc_load", {31'd0, load}, 32'd1);
    checkOutput("mode_inc_load_time", {8'd0, load_time}, {8'd0, 24'h100000});
    if (AL_EN) begin
      applyStimulus(1, 0, 0, 24'h080000, 0);
      applyStimulus(1, 0, 0, 24'h080000, 0);
    end

    // Reset while editing minutes: back to run, no load, tick after 4 cycles.
    applyStimulus(1, 0, 0, 24'h151500, 0);
    applyStimulus(1, 0, 0, 24'h151500, 0);
    applyStimulus(0, 1, 0, 24'h151500, 0);
    applyStimulus(0, 0, 1, 24'h151500, 0);
    checkOutput("midset_rst_blink", {30'd0, blink}, 32'd0);
    checkOutput("midset_rst_load", {31'd0, load}, 32'd0);
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(0, 0, 0, 24'h151500, 0);
      checkOutput($sformatf("midset_tick_%0d", n), {31'd0, tick}, {31'd0, n == 3});
      checkOutput("midset_no_load", {31'd0, load}, 32'd0);
    end

`ifdef CLOCK_SET_ALARM_EN
    // Program alarm 07:30 (time commit loads 12:00 along the way).
    applyStimulus(1, 0, 0, 24'h120000, 0);
    applyStimulus(1, 0, 0, 24'h120000, 0);
    applyStimulus(1, 0, 0, 24'h120000, 0);
    for (int n = 0; n < 7; n++) applyStimulus(0, 1, 0, 24'h120000, 0);
    applyStimulus(1, 0, 0, 24'h120000, 0);
    for (int n = 0; n < 30; n++) applyStimulus(0, 1, 0, 24'h120000, 0);
    applyStimulus(1, 0, 0, 24'h120000, 0);
    applyStimulus(0, 0, 0, 24'h072959, 1);
    checkOutput("alarm_before_match", {31'd0, alarm_out}, 32'd0);
    applyStimulus(0, 0, 0, 24'h073000, 1);
    checkOutput("alarm_on_match", {31'd0, alarm_out}, 32'd1);
    fell = 0;
    fall_at = 0;
    for (int n = 1; n <= 200; n++) begin
      if (!fell) begin
        applyStimulus(0, 0, 0, 24'h073000, 1);
        if (!alarm_out) begin
          fell = 1;
          fall_at = n;
        end
      end
    end
    checkOutput("alarm_fall_window", {31'd0, fell && fall_at > 116 && fall_at <= 121}, 32'd1);
    applyStimulus(0, 0, 0, 24'h072000, 1);
    applyStimulus(0, 0, 0, 24'h073000, 1);
    checkOutput("alarm_retrigger", {31'd0, alarm_out}, 32'd1);
    applyStimulus(0, 1, 0, 24'h073000, 1);
    checkOutput("alarm_inc_clear", {31'd0, alarm_out}, 32'd0);
    checkOutput("alarm_inc_blink", {30'd0, blink}, 32'd0);
    applyStimulus(0, 0, 0, 24'h072000, 0);
    applyStimulus(0, 0, 0, 24'h073000, 0);
    applyStimulus(0, 0, 0, 24'h073000, 0);
    checkOutput("alarm_disarmed", {31'd0, alarm_out}, 32'd0);
`else
    applyStimulus(0, 0, 0, 24'h072000, 1);
    applyStimulus(0, 0, 0, 24'h000000, 1);
    applyStimulus(0, 0, 0, 24'h000000, 1);
    checkOutput("alarm_tied_low", {31'd0, alarm_out}, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) rt = 24'($urandom());
      else if (sel <= 2) rt = {bcd(m_alhr), bcd(m_almn), 8'h00};
      else rt = {bcd(int'($urandom_range(0, 23))), bcd(int'($urandom_range(0, 59))),
                 bcd(int'($urandom_range(0, 59)))};
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 299) == 0, rt, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
